// File: rtl/xm_pkg.sv
// Shared types and constants for the XM memory access path.
// The byte-lane helper is kept here so DMA logic can reuse the same encodings.
package xm_pkg;

  typedef enum logic [1:0] {
    MA_IDLE,
    MA_REQ,
    MA_DONE
  } mem_acc_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Request fields held stable on the bus for the whole REQ phase.
  typedef struct packed {
    logic rw;
    logic byte_op;
    logic hi_lane;
  } mem_req_t;

  function automatic logic is_misaligned(input logic byte_op, input logic addr0);
    return !byte_op && addr0;
  endfunction

endpackage

// File: rtl/xm_byte_lane.sv
// Byte-lane steering for 16-bit words: write enables/data replication and
// read lane selection with zero extension. Purely combinational.
module xm_byte_lane
  import xm_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            byte_op_i,
  input  logic            hi_lane_i,
  input  logic [WORD-1:0] wr_data_i,
  input  logic [WORD-1:0] rd_raw_i,
  output logic [1:0]      be_o,
  output logic [WORD-1:0] wdata_o,
  output logic [WORD-1:0] rd_data_o
);

  logic [7:0] rd_lane;

  always_comb begin
    be_o      = BE_WORD;
    wdata_o   = wr_data_i;
    rd_lane   = hi_lane_i ? rd_raw_i[15:8] : rd_raw_i[7:0];
    rd_data_o = rd_raw_i;
    if (byte_op_i) begin
      be_o      = hi_lane_i ? BE_HI : BE_LO;
      wdata_o   = WORD'({wr_data_i[7:0], wr_data_i[7:0]});
      rd_data_o = WORD'(rd_lane);
    end
  end

endmodule

// File: rtl/xm_mem_access.sv
// Memory access unit: one req/ack bus cycle per memEn_i strobe, with byte-lane
// steering, misalignment check and an ack timeout.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  MA_IDLE | no access; memEn_i accepted
//  MA_REQ  | mem_req_o high, waiting for mem_ack_i or timeout
//  MA_DONE | one-cycle completion; memWr_o/fault_o pulse, memEn_i accepted
module xm_mem_access
  import xm_pkg::*;
#(
  parameter  int WORD    = 16,
  parameter  int TIMEOUT = 15,
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] addr_i,
  input  logic [WORD-1:0] wrData_i,
  output logic            memBusy_o,
  output logic            memWr_o,
  output logic [WORD-1:0] rdData_o,
  output logic            fault_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [1:0]      mem_be_o,
  output logic [WORD-1:0] mem_addr_o,
  output logic [WORD-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [WORD-1:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  mem_acc_state_t  state_q;
  mem_req_t        req_q;
  logic [WORD-1:1] addr_q;
  logic [WORD-1:0] wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic            busy_q, memwr_q, fault_q, bus_req_q;
  logic [WORD-1:0] rddata_q;

  logic [1:0]      lane_be;
  logic [WORD-1:0] lane_wdata, lane_rdata;
  logic            timeout_hit;

  xm_byte_lane #(.WORD(WORD)) u_lane (
    .byte_op_i (req_q.byte_op),
    .hi_lane_i (req_q.hi_lane),
    .wr_data_i (wdata_q),
    .rd_raw_i  (mem_rdata_i),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rd_data_o (lane_rdata)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT);

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= MA_IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      memwr_q   <= 1'b0;
      fault_q   <= 1'b0;
      bus_req_q <= 1'b0;
      rddata_q  <= '0;
    end else begin
      memwr_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        MA_IDLE, MA_DONE: begin
          if (!memEn_i) begin
            state_q <= MA_IDLE;
          end else if (is_misaligned(byteOp_i, addr_i[0])) begin
            state_q <= MA_DONE;
            fault_q <= 1'b1;
          end else begin
            state_q   <= MA_REQ;
            req_q     <= '{rw: memRW_i, byte_op: byteOp_i, hi_lane: addr_i[0]};
            addr_q    <= addr_i[WORD-1:1];
            wdata_q   <= wrData_i;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            bus_req_q <= 1'b1;
          end
        end
        MA_REQ: begin
          // ack takes priority over a timeout expiring in the same cycle
          if (mem_ack_i) begin
            state_q   <= MA_DONE;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            if (!req_q.rw) begin
              rddata_q <= lane_rdata;
              memwr_q  <= 1'b1;
            end
          end else if (timeout_hit) begin
            state_q   <= MA_DONE;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= MA_IDLE;
      endcase
    end
  end

  assign memBusy_o   = busy_q;
  assign memWr_o     = memwr_q;
  assign fault_o     = fault_q;
  assign rdData_o    = rddata_q;
  assign mem_req_o   = bus_req_q;
  assign mem_we_o    = bus_req_q & req_q.rw;
  assign mem_be_o    = bus_req_q ? lane_be : 2'b00;
  assign mem_addr_o  = {addr_q, 1'b0};
  assign mem_wdata_o = lane_wdata;

endmodule

// File: tb/tb_xm_mem_access.sv
// Directed bench for xm_mem_access: acts as bus slave with a programmable
// number of wait cycles and checks bus-side and controller-side results.
module tb_xm_mem_access;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b0;
  logic        memEn_i = 1'b0, memRW_i = 1'b0, byteOp_i = 1'b0;
  logic [15:0] addr_i = '0, wrData_i = '0;
  logic        memBusy_o, memWr_o, fault_o;
  logic [15:0] rdData_o;
  logic        mem_req_o, mem_we_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  int          r_busy;
  logic        r_wr, r_fault, r_req, r_we, r_tmo;
  logic [15:0] r_addr, r_wdata;
  logic [1:0]  r_be;

  xm_mem_access #(.WORD(16), .TIMEOUT(15)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .memEn_i     (memEn_i),
    .memRW_i     (memRW_i),
    .byteOp_i    (byteOp_i),
    .addr_i      (addr_i),
    .wrData_i    (wrData_i),
    .memBusy_o   (memBusy_o),
    .memWr_o     (memWr_o),
    .rdData_o    (rdData_o),
    .fault_o     (fault_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issuing memEn_i while an access is in flight is a protocol violation.
  always @(negedge clk_i)
    if (arst_i && memEn_i) chk("en_while_busy", memBusy_o, 0);

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, memBusy_o, 0);
    chk({tag, "_wr"}, memWr_o, 0);
    chk({tag, "_fault"}, fault_o, 0);
    chk({tag, "_rd"}, rdData_o, 0);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_we"}, mem_we_o, 0);
    chk({tag, "_be"}, mem_be_o, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
  endtask

  // Starts an access and returns once the DUT drops busy (DONE cycle).
  // waits < 0 means the slave never acknowledges.
  task automatic access(input logic rw, input logic bt, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd, input int waits);
    int w;
    w = 0;
    r_busy = 0; r_wr = 0; r_fault = 0; r_req = 0; r_we = 0; r_tmo = 1;
    r_addr = '0; r_wdata = '0; r_be = '0;
    memEn_i = 1'b1; memRW_i = rw; byteOp_i = bt; addr_i = a; wrData_i = wd;
    tick();
    memEn_i = 1'b0;
    for (int n = 0; n < 40; n++) begin
      mem_ack_i = 1'b0;
      if (memWr_o) r_wr = 1'b1;
      if (fault_o) r_fault = 1'b1;
      if (mem_req_o) begin
        r_req = 1'b1; r_addr = mem_addr_o; r_be = mem_be_o;
        r_wdata = mem_wdata_o; r_we = mem_we_o;
      end
      if (!memBusy_o) begin
        r_tmo = 1'b0;
        break;
      end
      r_busy++;
      if (mem_req_o) begin
        if (w == waits) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = rd;
        end
        w++;
      end
      tick();
    end
    mem_ack_i = 1'b0;
    chk("cycle_budget", r_tmo, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("in_rst");
    arst_i = 1'b1;
    tick();
    check_zero("rst");

    // word read, two wait cycles
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2);
    chk("t1_busy", r_busy, 3);
    chk("t1_req", r_req, 1);
    chk("t1_addr", r_addr, 16'h0010);
    chk("t1_be", r_be, 2'b11);
    chk("t1_we", r_we, 0);
    chk("t1_wr", r_wr, 1);
    chk("t1_fault", r_fault, 0);
    chk("t1_rd", rdData_o, 16'hBEEF);
    tick();
    chk("t1_wr_pulse", memWr_o, 0);
    chk("t1_rd_hold", rdData_o, 16'hBEEF);

    // byte store to odd address
    access(1'b1, 1'b1, 16'h0021, 16'h12A5, 16'h0000, 0);
    chk("t2_busy", r_busy, 1);
    chk("t2_addr", r_addr, 16'h0020);
    chk("t2_be", r_be, 2'b10);
    chk("t2_wdata", r_wdata, 16'hA5A5);
    chk("t2_we", r_we, 1);
    chk("t2_wr", r_wr, 0);
    chk("t2_rd", rdData_o, 16'hBEEF);

    // word store back-to-back
    access(1'b1, 1'b0, 16'h0040, 16'h1234, 16'h0000, 0);
    chk("t2b_be", r_be, 2'b11);
    chk("t2b_wdata", r_wdata, 16'h1234);
    chk("t2b_addr", r_addr, 16'h0040);

    // byte reads, high and low lane
    access(1'b0, 1'b1, 16'h0031, 16'h0000, 16'h7F80, 0);
    chk("t3_be", r_be, 2'b10);
    chk("t3_addr", r_addr, 16'h0030);
    chk("t3_wr", r_wr, 1);
    chk("t3_rd", rdData_o, 16'h007F);
    access(1'b0, 1'b1, 16'h0030, 16'h0000, 16'h7F80, 0);
    chk("t3b_be", r_be, 2'b01);
    chk("t3b_rd", rdData_o, 16'h0080);

    // misaligned word read
    access(1'b0, 1'b0, 16'h0003, 16'h0000, 16'hDEAD, 0);
    chk("t4_req", r_req, 0);
    chk("t4_busy", r_busy, 0);
    chk("t4_fault", r_fault, 1);
    chk("t4_wr", r_wr, 0);
    chk("t4_rd", rdData_o, 16'h0080);
    tick();
    chk("t4_fault_pulse", fault_o, 0);

    // timeout, then back-to-back accept in DONE
    access(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, -1);
    chk("t5_busy", r_busy, 16);
    chk("t5_fault", r_fault, 1);
    chk("t5_wr", r_wr, 0);
    chk("t5_req_drop", mem_req_o, 0);
    chk("t5_rd", rdData_o, 16'h0080);
    access(1'b0, 1'b0, 16'h0060, 16'h0000, 16'h5A5A, 0);
    chk("t5b_busy", r_busy, 1);
    chk("t5b_wr", r_wr, 1);
    chk("t5b_fault", r_fault, 0);
    chk("t5b_rd", rdData_o, 16'h5A5A);

    // ack in the same cycle the timeout expires counts as ack
    access(1'b0, 1'b0, 16'h0062, 16'h0000, 16'h0C0C, 15);
    chk("t5c_busy", r_busy, 16);
    chk("t5c_wr", r_wr, 1);
    chk("t5c_fault", r_fault, 0);
    chk("t5c_rd", rdData_o, 16'h0C0C);

    // asynchronous reset in the middle of REQ, coinciding with ack
    tick();
    memEn_i = 1'b1; memRW_i = 1'b0; byteOp_i = 1'b0; addr_i = 16'h0070;
    tick();
    memEn_i = 1'b0;
    chk("t6_req_up", mem_req_o, 1);
    mem_ack_i = 1'b1;
    mem_rdata_i = 16'hFFFF;
    #2 arst_i = 1'b0;
    #1;
    chk("t6_req_async", mem_req_o, 0);
    chk("t6_busy_async", memBusy_o, 0);
    chk("t6_rd_async", rdData_o, 0);
    tick();
    mem_ack_i = 1'b0;
    arst_i = 1'b1;
    tick();
    check_zero("t6_post");

    // unit works normally after reset
    access(1'b0, 1'b0, 16'h0080, 16'h0000, 16'h1357, 1);
    chk("t7_busy", r_busy, 2);
    chk("t7_wr", r_wr, 1);
    chk("t7_rd", rdData_o, 16'h1357);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
